// File: rtl/ether_tx_pkg.sv
// ether_tx_pkg
//   Shared types and helpers for the Ethernet TX frame arbiter.
//   - state_t  : arbiter FSM states
//   - DEF_*    : default parameter values for ether_tx_arbiter
//   - keep_w() : TKEEP width for a given TDATA width
//   - cnt_w()  : word-counter width able to hold 0..max_words
//   - rr_pick(): round-robin search over up to 8 request lines
//   - rr_next(): next round-robin start index after a grant
package ether_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam int DEF_NUM_CH          = 4;
    localparam int DEF_TDATA_WIDTH     = 64;
    localparam int DEF_MAX_FRAME_WORDS = 128;
    localparam int DEF_GAP_CYCLES      = 2;

    function automatic int keep_w(input int tdata_width);
        return tdata_width / 8;
    endfunction

    function automatic int cnt_w(input int max_words);
        return $clog2(max_words + 1);
    endfunction

    localparam int KEEP_W = keep_w(DEF_TDATA_WIDTH);
    localparam int CNT_W  = cnt_w(DEF_MAX_FRAME_WORDS);

    // Returns {hit, index}: first set bit of req[0..n-1], scanning upward
    // from start and wrapping. The scan runs backwards so the nearest
    // candidate to start is the last one written and therefore wins.
    function automatic logic [3:0] rr_pick(input logic [7:0] req,
                                           input logic [2:0] start,
                                           input int         n);
        logic [3:0] res;
        int         idx;
        res = '0;
        for (int k = 7; k >= 0; k--) begin
            if (k < n) begin
                idx = (int'(start) + k) % n;
                if (req[idx[2:0]]) res = {1'b1, idx[2:0]};
            end
        end
        return res;
    endfunction

    function automatic logic [2:0] rr_next(input logic [2:0] idx, input int n);
        return (int'(idx) == n - 1) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// axis_skid_reg
//   Two-entry AXI-Stream register slice. The output is fully registered and
//   in_ready depends only on local state, which cuts the ready path from the
//   MAC back to the channel sources.
//   Ports:
//     clk, rst              : clock, synchronous active-high reset
//     in_data/valid/ready   : upstream stream
//     out_data/valid/ready  : downstream stream (registered)
//   Handshake: a word moves when valid and ready are both high at a rising
//   edge; valid never waits on ready, and data holds while valid && !ready.
module axis_skid_reg #(
    parameter int W = 74
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] skid_data;
    logic         skid_valid;

    // Accept whenever the spare entry is free; a word arriving during a stall
    // parks there and ready drops the following cycle.
    assign in_ready = ~skid_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
        end else if (!out_valid || out_ready) begin
            // Output register is free this cycle: refill from the spare entry
            // first so ordering is preserved.
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= in_valid;
                if (in_valid) out_data <= in_data;
            end
        end else if (in_valid && in_ready) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/ether_tx_arbiter.sv
// ether_tx_arbiter
//   Round-robin frame scheduler sharing one TX AXI-Stream path among NUM_CH
//   sources. One channel is granted per frame; frames longer than
//   MAX_FRAME_WORDS are cut (TLAST+TUSER) and the rest is drained; GAP_CYCLES
//   idle cycles follow every emitted TLAST.
//   Ports:
//     TX_ACLK, TX_ARESET          : clock, synchronous active-high reset
//     CH_TDATA/TKEEP/TVALID/TLAST : packed per-channel source streams
//     CH_TREADY                   : per-channel accept (one-hot or zero)
//     TX_M_AXIS_*                 : registered MAC stream, TUSER = truncated
//     GRANT_CH                    : currently granted channel
//     BUSY                        : FSM not in IDLE
//     TRUNC_CNT                   : saturating truncated-frame count
//   Handshake: every stream transfers a word when TVALID and TREADY are both
//   high at a rising edge; TVALID never depends on TREADY and payload holds
//   while TVALID && !TREADY.
module ether_tx_arbiter
    import ether_tx_pkg::*;
#(
    parameter int NUM_CH          = DEF_NUM_CH,
    parameter int TDATA_WIDTH     = DEF_TDATA_WIDTH,
    parameter int MAX_FRAME_WORDS = DEF_MAX_FRAME_WORDS,
    parameter int GAP_CYCLES      = DEF_GAP_CYCLES
) (
    input  logic                            TX_ACLK,
    input  logic                            TX_ARESET,
    input  logic [NUM_CH*TDATA_WIDTH-1:0]   CH_TDATA,
    input  logic [NUM_CH*TDATA_WIDTH/8-1:0] CH_TKEEP,
    input  logic [NUM_CH-1:0]               CH_TVALID,
    input  logic [NUM_CH-1:0]               CH_TLAST,
    output logic [NUM_CH-1:0]               CH_TREADY,
    output logic [TDATA_WIDTH-1:0]          TX_M_AXIS_TDATA,
    output logic [TDATA_WIDTH/8-1:0]        TX_M_AXIS_TKEEP,
    output logic                            TX_M_AXIS_TVALID,
    output logic                            TX_M_AXIS_TLAST,
    output logic                            TX_M_AXIS_TUSER,
    input  logic                            TX_M_AXIS_TREADY,
    output logic [2:0]                      GRANT_CH,
    output logic                            BUSY,
    output logic [15:0]                     TRUNC_CNT
);

    localparam int KW = keep_w(TDATA_WIDTH);
    localparam int CW = cnt_w(MAX_FRAME_WORDS);
    localparam int SW = TDATA_WIDTH + KW + 2;

    state_t        state;
    logic [2:0]    grant;
    logic [2:0]    rr_ptr;      // channel the next search starts from
    logic [CW-1:0] word_cnt;    // words accepted so far in this frame
    logic [3:0]    gap_cnt;
    logic [15:0]   trunc_cnt;
    logic          busy;

    logic                   pick_hit;
    logic [2:0]             pick_idx;
    logic [TDATA_WIDTH-1:0] g_data;
    logic [KW-1:0]          g_keep;
    logic                   g_valid;
    logic                   g_last;
    logic                   g_ready;
    logic                   xfer;
    logic                   at_max;
    logic                   in_last;
    logic                   in_user;
    logic                   skid_in_ready;
    logic [SW-1:0]          skid_in;
    logic [SW-1:0]          skid_out;

    always_comb begin
        {pick_hit, pick_idx} = rr_pick(8'(CH_TVALID), rr_ptr, NUM_CH);
    end

    // Granted-channel mux.
    always_comb begin
        g_data  = '0;
        g_keep  = '0;
        g_valid = 1'b0;
        g_last  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant == 3'(i)) begin
                g_data  = CH_TDATA[i*TDATA_WIDTH +: TDATA_WIDTH];
                g_keep  = CH_TKEEP[i*KW +: KW];
                g_valid = CH_TVALID[i];
                g_last  = CH_TLAST[i];
            end
        end
    end

    // DRAIN discards words, so it accepts regardless of the skid state.
    assign g_ready = ((state == SEND) && skid_in_ready) || (state == DRAIN);
    assign xfer    = g_valid && g_ready;

    always_comb begin
        CH_TREADY = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant == 3'(i)) CH_TREADY[i] = g_ready;
        end
    end

    // The word being accepted is word number MAX_FRAME_WORDS.
    assign at_max  = (word_cnt == CW'(MAX_FRAME_WORDS - 1));
    assign in_last = g_last || at_max;
    assign in_user = at_max && !g_last;
    assign skid_in = {g_data, g_keep, in_last, in_user};

    axis_skid_reg #(
        .W (SW)
    ) u_skid (
        .clk       (TX_ACLK),
        .rst       (TX_ARESET),
        .in_data   (skid_in),
        .in_valid  ((state == SEND) && g_valid),
        .in_ready  (skid_in_ready),
        .out_data  (skid_out),
        .out_valid (TX_M_AXIS_TVALID),
        .out_ready (TX_M_AXIS_TREADY)
    );

    assign {TX_M_AXIS_TDATA, TX_M_AXIS_TKEEP, TX_M_AXIS_TLAST, TX_M_AXIS_TUSER} = skid_out;

    always_ff @(posedge TX_ACLK) begin
        if (TX_ARESET) begin
            state     <= IDLE;
            grant     <= 3'd0;
            rr_ptr    <= 3'd0;
            word_cnt  <= '0;
            gap_cnt   <= '0;
            trunc_cnt <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_hit) begin
                        grant    <= pick_idx;
                        rr_ptr   <= rr_next(pick_idx, NUM_CH);
                        word_cnt <= '0;
                        state    <= SEND;
                        busy     <= 1'b1;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        word_cnt <= word_cnt + CW'(1);
                        if (g_last) begin
                            gap_cnt <= '0;
                            if (GAP_CYCLES == 0) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= GAP;
                            end
                        end else if (at_max) begin
                            if (trunc_cnt != 16'hFFFF) trunc_cnt <= trunc_cnt + 16'd1;
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (xfer && g_last) begin
                        gap_cnt <= '0;
                        if (GAP_CYCLES == 0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    // Nothing enters the slice in GAP, so an empty output means
                    // the TLAST word has left; only then does the gap count.
                    if (!TX_M_AXIS_TVALID) begin
                        if (gap_cnt == 4'(GAP_CYCLES - 1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign GRANT_CH  = grant;
    assign BUSY      = busy;
    assign TRUNC_CNT = trunc_cnt;

endmodule
